// File: rtl/bus_deserializer_if.sv
// Serial receive lane bundle between the serial source and bus_deserializer.
// The source side drives the serial stream; the deserializer side returns the framed words.
interface bus_deserializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  serial_in;
    logic                  serial_valid;
    logic                  resync;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  sync_det;
    logic                  locked;

    modport master (
        output serial_in, serial_valid, resync,
        input  parallel_data, data_valid, sync_det, locked
    );

    modport slave (
        input  serial_in, serial_valid, resync,
        output parallel_data, data_valid, sync_det, locked
    );
endinterface

// File: rtl/bus_deserializer.sv
// MSB-first serial-to-parallel receiver: hunts for SYNC_WORD, then emits one word per DATA_WIDTH bits.
// Any valid gap or resync drops alignment and restarts the hunt.
module bus_deserializer #(
    parameter int unsigned             DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]   SYNC_WORD  = DATA_WIDTH'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    bus_deserializer_if.slave bus
);
    localparam int unsigned           CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      fill_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  sync_det;
    logic                  locked;
    logic [DATA_WIDTH-1:0] next_word;

    assign next_word = {shift_reg[DATA_WIDTH-2:0], bus.serial_in};

    // Alignment FSM, shifter and word output; a dropped stream wins over the sampled bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            shift_reg     <= '0;
            fill_cnt      <= '0;
            bit_cnt       <= '0;
            parallel_data <= '0;
            data_valid    <= 1'b0;
            sync_det      <= 1'b0;
            locked        <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sync_det   <= 1'b0;
            if (bus.resync || !bus.serial_valid) begin
                state     <= HUNT;
                locked    <= 1'b0;
                shift_reg <= '0;
                fill_cnt  <= '0;
                bit_cnt   <= '0;
            end else begin
                shift_reg <= next_word;
                case (state)
                    HUNT: begin
                        if (fill_cnt == CNT_LAST) begin
                            if (next_word == SYNC_WORD) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                bit_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (bit_cnt == CNT_LAST) begin
                            parallel_data <= next_word;
                            data_valid    <= 1'b1;
                            sync_det      <= (next_word == SYNC_WORD);
                            bit_cnt       <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.parallel_data = parallel_data;
    assign bus.data_valid    = data_valid;
    assign bus.sync_det      = sync_det;
    assign bus.locked        = locked;
endmodule

// File: tb/tb_bus_deserializer.sv
// Randomized scoreboard bench for bus_deserializer against a bit-queue framing model.
// The driver steps the model and queues expectations; a monitor compares every cycle.
module tb_bus_deserializer;
    localparam int unsigned     DW   = 8;
    localparam logic [DW-1:0]   SYNC = 8'hA5;

    typedef struct packed {
        logic lock;
        logic dv;
        logic sd;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bus_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    bus_deserializer #(.DATA_WIDTH(DW), .SYNC_WORD(SYNC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          mon_en = 1'b0;

    bit          hist[$];
    bit          part[$];
    bit          m_lock = 1'b0;
    cyc_t        cyc_q[$];
    logic [DW-1:0] word_q[$];
    logic [DW-1:0] last_word = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] pack_bits(input bit q[$]);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < q.size(); i++) v = {v[DW-2:0], q[i]};
        return v;
    endfunction

    // Framing model: last DW bits seen since a restart must equal SYNC to lock, then groups of DW bits are words.
    function automatic void model_step(bit v, bit b, bit rs);
        cyc_t e = '0;
        if (rs || !v) begin
            hist.delete();
            part.delete();
            m_lock = 1'b0;
        end else if (!m_lock) begin
            hist.push_back(b);
            if (hist.size() > DW) void'(hist.pop_front());
            if (hist.size() == DW && pack_bits(hist) == SYNC) begin
                m_lock = 1'b1;
                hist.delete();
                part.delete();
            end
        end else begin
            part.push_back(b);
            if (part.size() == DW) begin
                logic [DW-1:0] w = pack_bits(part);
                e.dv = 1'b1;
                e.sd = (w == SYNC);
                word_q.push_back(w);
                part.delete();
            end
        end
        e.lock = m_lock;
        cyc_q.push_back(e);
    endfunction

    task automatic send_bit(input bit v, input bit b, input bit rs);
        @(negedge clk);
        bus.serial_valid = v;
        bus.serial_in    = b;
        bus.resync       = rs;
        model_step(v, b, rs);
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) send_bit(1'b1, w[i], 1'b0);
    endtask

    // Monitor: every enabled cycle consumes one cycle expectation; data pulses consume a word.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                cyc_t e;
                if (cyc_q.size() == 0) begin
                    check("cycle_queue_underflow", 32'd1, 32'd0);
                    e = '0;
                end else begin
                    e = cyc_q.pop_front();
                end
                check("locked", 32'(bus.locked), 32'(e.lock));
                check("data_valid", 32'(bus.data_valid), 32'(e.dv));
                check("sync_det", 32'(bus.sync_det), 32'(e.sd));
                if (bus.data_valid) begin
                    if (word_q.size() == 0) begin
                        check("word_queue_underflow", 32'd1, 32'd0);
                    end else begin
                        last_word = word_q.pop_front();
                        check("parallel_data", 32'(bus.parallel_data), 32'(last_word));
                    end
                end else begin
                    check("parallel_data_hold", 32'(bus.parallel_data), 32'(last_word));
                end
            end
        end
    end

    initial begin
        bus.serial_in    = 1'b0;
        bus.serial_valid = 1'b0;
        bus.resync       = 1'b0;

        // Reset held for 3 cycles while bits keep arriving.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.serial_valid = 1'b1;
            bus.serial_in    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("rst_parallel_data", 32'(bus.parallel_data), 32'd0);
            check("rst_data_valid", 32'(bus.data_valid), 32'd0);
            check("rst_sync_det", 32'(bus.sync_det), 32'd0);
            check("rst_locked", 32'(bus.locked), 32'd0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        check("post_rst_parallel_data", 32'(bus.parallel_data), 32'd0);
        check("post_rst_locked", 32'(bus.locked), 32'd0);

        // Restart cleanly, then lock and receive two words.
        send_bit(1'b0, 1'b0, 1'b0);
        send_word(SYNC);
        send_word(8'h3C);
        send_word(8'hF0);

        // Misaligned hunt with junk prefix.
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_word(SYNC);
        send_word(8'h81);

        // Sync word appearing as data keeps lock.
        send_word(SYNC);
        send_word(8'h5A);

        // Interruption mid-word, then re-lock.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_word(SYNC);
        send_word(8'h12);

        // Resync on the bit that would complete 8'h77.
        for (int i = DW - 1; i >= 1; i--) send_bit(1'b1, 1'((8'h77 >> i) & 1), 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        send_word(SYNC);
        send_word(8'hC3);

        // Randomized mix of sync words, data words, gaps, resyncs and stray bits.
        for (int it = 0; it < 300; it++) begin
            int unsigned r = $urandom_range(0, 9);
            if (r <= 3) begin
                send_word(SYNC);
            end else if (r <= 6) begin
                send_word(DW'($urandom));
            end else if (r == 7) begin
                send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else if (r == 8) begin
                send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                int unsigned n = $urandom_range(1, 5);
                for (int k = 0; k < int'(n); k++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        send_bit(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("words_outstanding", 32'(word_q.size()), 32'd0);
        check("cycles_outstanding", 32'(cyc_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
